// File: rtl/alu_pipe_param_if.sv
// Operand/result handshake bundle for alu_pipe_param.
interface alu_pipe_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [4:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] alu_out;
  logic               carry_out;
  logic               zero;

  // Producer/consumer side (datapath and writeback)
  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, alu_out, carry_out, zero
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, alu_out, carry_out, zero
  );
endinterface

// File: rtl/alu_pipe_param.sv
// Handshaked 32-function ALU with generic operand width, 2*WIDTH result,
// carry/borrow and zero flags, and an optional iterative shift-add multiplier.
module alu_pipe_param #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          MUL_ITER = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_pipe_param_if.slave alu_io
);

  localparam int unsigned     RW       = 2 * WIDTH;
  localparam int unsigned     CntW     = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] IterLast = CntW'(WIDTH);
  localparam logic [4:0]      OpMul    = 5'b00010;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q;
  logic            in_ready_q, out_valid_q;
  logic [RW-1:0]   alu_out_q;
  logic            carry_q, zero_q;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CntW-1:0] cnt_q;

  logic [WIDTH-1:0] a, b;
  logic [RW-1:0]    za, zb, res_c;
  logic             carry_c;

  // Combinational result/carry for the operands currently on the input bus
  always_comb begin
    a       = alu_io.a;
    b       = alu_io.b;
    za      = {{WIDTH{1'b0}}, a};
    zb      = {{WIDTH{1'b0}}, b};
    res_c   = '0;
    carry_c = 1'b0;
    case (alu_io.opcode)
      5'b00000: begin res_c = za + zb; carry_c = res_c[WIDTH]; end
      5'b00001: begin res_c = za - zb; carry_c = (a < b); end
      5'b00010: res_c = za * zb;
      5'b00011: begin res_c = zb - za; carry_c = (b < a); end
      5'b00100: begin res_c = za + RW'(1); carry_c = (a == {WIDTH{1'b1}}); end
      5'b00101: begin res_c = za - RW'(1); carry_c = (a == '0); end
      5'b00110: res_c = '0 - za;
      5'b00111: res_c = '0 - zb;
      5'b01000: res_c = za;
      5'b01001: res_c = zb;
      5'b01010, 5'b01100: res_c = za << 1;
      5'b01011, 5'b01101: res_c = za >> 1;
      5'b01110, 5'b10000: res_c = zb << 1;
      5'b01111, 5'b10001: res_c = zb >> 1;
      5'b10010: res_c = {{WIDTH{1'b0}}, a[WIDTH-2:0], a[WIDTH-1]};
      5'b10011: res_c = {{WIDTH{1'b0}}, a[0], a[WIDTH-1:1]};
      5'b10100: res_c = {{WIDTH{1'b0}}, b[WIDTH-2:0], b[WIDTH-1]};
      5'b10101: res_c = {{WIDTH{1'b0}}, b[0], b[WIDTH-1:1]};
      5'b10110: res_c = ~za;
      5'b10111: res_c = ~zb;
      5'b11000: res_c = za & zb;
      5'b11001: res_c = za | zb;
      5'b11010: res_c = za ^ zb;
      5'b11011: res_c = ~(za | zb);
      5'b11100: res_c = ~(za & zb);
      5'b11101: res_c = ~(za ^ zb);
      5'b11110: res_c = {{(RW-1){1'b0}}, (a > b)};
      5'b11111: res_c = {{(RW-1){1'b0}}, (a == b)};
      default:  res_c = '0;
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
  end

  // Control FSM with registered handshake outputs and result/flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (alu_io.in_valid) begin
            in_ready_q <= 1'b0;
            if (MUL_ITER && (alu_io.opcode == OpMul)) begin
              state_q  <= StMul;
              acc_q    <= '0;
              cnt_q    <= '0;
              mcand_q  <= za;
              mplier_q <= b;
            end else begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              alu_out_q   <= res_c;
              carry_q     <= carry_c;
              zero_q      <= (res_c == '0);
            end
          end
        end
        StMul: begin
          if (cnt_q == IterLast) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            alu_out_q   <= acc_q;
            carry_q     <= 1'b0;
            zero_q      <= (acc_q == '0);
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          // Drain cycle never accepts; earliest new accept is the next cycle
          if (alu_io.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_io.in_ready  = in_ready_q;
  assign alu_io.out_valid = out_valid_q;
  assign alu_io.alu_out   = alu_out_q;
  assign alu_io.carry_out = carry_q;
  assign alu_io.zero      = zero_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed bench for alu_pipe_param: iterative-multiply and single-cycle instances.
module tb_alu_pipe_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_pipe_param_if #(.WIDTH(8)) bus0 ();
  alu_pipe_param_if #(.WIDTH(8)) bus1 ();

  alu_pipe_param #(.WIDTH(8), .MUL_ITER(1'b1)) u_dut_iter (
    .clk_i  (clk),
    .rst_i  (rst),
    .alu_io (bus0)
  );

  alu_pipe_param #(.WIDTH(8), .MUL_ITER(1'b0)) u_dut_comb (
    .clk_i  (clk),
    .rst_i  (rst),
    .alu_io (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operation on bus0 for exactly one accept edge
  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    bus0.opcode   = op;
    bus0.a        = a;
    bus0.b        = b;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] eo, input logic ec,
                          input logic ez, input int lat);
    int n;
    bus0.out_ready = 1'b1;
    issue(op, a, b);
    n = 0;
    while (bus0.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_out"}, {16'h0, bus0.alu_out}, {16'h0, eo});
    check({tag, "_carry"}, {31'h0, bus0.carry_out}, {31'h0, ec});
    check({tag, "_zero"}, {31'h0, bus0.zero}, {31'h0, ez});
    tick();
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus0.a = '0; bus0.b = '0; bus0.opcode = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.opcode = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", {31'h0, bus0.in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, bus0.out_valid}, 32'h0);
    check("rst_alu_out", {16'h0, bus0.alu_out}, 32'h0);
    check("rst_carry", {31'h0, bus0.carry_out}, 32'h0);
    check("rst_zero", {31'h0, bus0.zero}, 32'h0);
    check("rst_in_ready_comb", {31'h0, bus1.in_ready}, 32'h1);

    // ADD with carry, latency 1, back to idle one cycle later
    bus0.out_ready = 1'b1;
    issue(5'b00000, 8'hFF, 8'h01);
    check("add_valid", {31'h0, bus0.out_valid}, 32'h1);
    check("add_in_ready", {31'h0, bus0.in_ready}, 32'h0);
    check("add_out", {16'h0, bus0.alu_out}, 32'h0100);
    check("add_carry", {31'h0, bus0.carry_out}, 32'h1);
    check("add_zero", {31'h0, bus0.zero}, 32'h0);
    tick();
    check("add_idle_valid", {31'h0, bus0.out_valid}, 32'h0);
    check("add_idle_ready", {31'h0, bus0.in_ready}, 32'h1);

    // Iterative multiply: 9 busy cycles, result after the 9th edge past accept
    issue(5'b00010, 8'hFF, 8'hFF);
    for (int i = 0; i < 9; i++) begin
      check("mul_busy_ready", {31'h0, bus0.in_ready}, 32'h0);
      check("mul_busy_valid", {31'h0, bus0.out_valid}, 32'h0);
      tick();
    end
    check("mul_valid", {31'h0, bus0.out_valid}, 32'h1);
    check("mul_out", {16'h0, bus0.alu_out}, 32'hFE01);
    check("mul_carry", {31'h0, bus0.carry_out}, 32'h0);
    check("mul_zero", {31'h0, bus0.zero}, 32'h0);
    tick();
    check("mul_drained", {31'h0, bus0.in_ready}, 32'h1);

    // Single-cycle multiply instance: latency 1
    bus1.out_ready = 1'b1;
    bus1.opcode = 5'b00010; bus1.a = 8'hFF; bus1.b = 8'hFF;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check("mul1_valid", {31'h0, bus1.out_valid}, 32'h1);
    check("mul1_out", {16'h0, bus1.alu_out}, 32'hFE01);
    tick();
    check("mul1_drained", {31'h0, bus1.out_valid}, 32'h0);

    // Subtract with borrow both directions
    op_check("sub", 5'b00001, 8'h03, 8'h05, 16'hFFFE, 1'b1, 1'b0, 0);
    op_check("bsuba", 5'b00011, 8'h03, 8'h05, 16'h0002, 1'b0, 1'b0, 0);

    // Backpressure with an ignored second request during the stall
    bus0.out_ready = 1'b0;
    issue(5'b11010, 8'hAA, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, bus0.out_valid}, 32'h1);
      check("bp_out", {16'h0, bus0.alu_out}, 32'h0);
      check("bp_zero", {31'h0, bus0.zero}, 32'h1);
      check("bp_in_ready", {31'h0, bus0.in_ready}, 32'h0);
      if (i == 1) begin
        bus0.opcode = 5'b00000; bus0.a = 8'h01; bus0.b = 8'h01;
      end
      bus0.in_valid = (i == 1);
      tick();
    end
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    check("bp_drain_valid", {31'h0, bus0.out_valid}, 32'h0);
    check("bp_drain_ready", {31'h0, bus0.in_ready}, 32'h1);
    check("bp_held_out", {16'h0, bus0.alu_out}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_queue", {31'h0, bus0.out_valid}, 32'h0);
    end

    // Assorted opcodes and flag boundaries
    op_check("inc_ff", 5'b00100, 8'hFF, 8'h00, 16'h0100, 1'b1, 1'b0, 0);
    op_check("dec_0", 5'b00101, 8'h00, 8'h00, 16'hFFFF, 1'b1, 1'b0, 0);
    op_check("neg_b", 5'b00111, 8'h00, 8'h01, 16'hFFFF, 1'b0, 1'b0, 0);
    op_check("shl_b", 5'b01110, 8'h00, 8'h80, 16'h0100, 1'b0, 1'b0, 0);
    op_check("shl_b_alt", 5'b10000, 8'h00, 8'hC1, 16'h0182, 1'b0, 1'b0, 0);
    op_check("shr_a", 5'b01011, 8'h81, 8'h00, 16'h0040, 1'b0, 1'b0, 0);
    op_check("ror_b", 5'b10101, 8'h00, 8'h01, 16'h0080, 1'b0, 1'b0, 0);
    op_check("not_a", 5'b10110, 8'h0F, 8'h00, 16'hFFF0, 1'b0, 1'b0, 0);
    op_check("nor", 5'b11011, 8'h00, 8'h00, 16'hFFFF, 1'b0, 1'b0, 0);
    op_check("nand", 5'b11100, 8'hFF, 8'hFF, 16'hFF00, 1'b0, 1'b0, 0);
    op_check("xnor", 5'b11101, 8'h0F, 8'hF0, 16'hFF00, 1'b0, 1'b0, 0);
    op_check("rol_a", 5'b10010, 8'h81, 8'h00, 16'h0003, 1'b0, 1'b0, 0);
    op_check("gt", 5'b11110, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b1, 0);
    op_check("eq", 5'b11111, 8'h05, 8'h05, 16'h0001, 1'b0, 1'b0, 0);
    op_check("mul_small", 5'b00010, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 9);

    // Reset sampled on the edge of the 3rd multiply iteration
    bus0.out_ready = 1'b1;
    issue(5'b00010, 8'hFF, 8'hFF);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", {31'h0, bus0.in_ready}, 32'h1);
    check("abort_valid", {31'h0, bus0.out_valid}, 32'h0);
    check("abort_out", {16'h0, bus0.alu_out}, 32'h0);
    check("abort_carry", {31'h0, bus0.carry_out}, 32'h0);
    check("abort_zero", {31'h0, bus0.zero}, 32'h0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("abort_no_stale", {31'h0, bus0.out_valid}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised, handshaked successor to the team's 8-bit 32-function combinational ALU.
- Operand width is generic. Operands and opcode are captured on a valid/ready input handshake, and results are held on a valid/ready output handshake.
- Multiply runs either as an iterative shift-add over WIDTH cycles or in a single cycle, selected by parameter.
- Sits between the datapath operand registers and the writeback stage, and adds per-operation carry/borrow and zero flags.

Parameters:
- WIDTH, 8, operand width in bits. Result width is 2*WIDTH.
- MUL_ITER, 1, 1 = iterative shift-add multiply (WIDTH cycles); 0 = single-cycle multiply.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operand/opcode valid.
- InReady  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Opcode  input  5  operation select.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts the result.
- ALU_Out  output  2*WIDTH  registered result.
- CarryOut  output  1  carry/borrow flag for the held result.
- Zero  output  1  1 when ALU_Out == 0.

Behaviour:
- Reset: synchronous, active-high, one clock, one reset.
  - Reset value of all outputs: ALU_Out=0, CarryOut=0, Zero=0, OutValid=0, InReady=1.
  - State after reset: IDLE.
  - Reset has priority over all other events and aborts any operation in flight, including mid-multiply. The aborted result is never presented.
- States: IDLE, MUL, DONE.
  - InReady=1 only in IDLE.
  - OutValid=1 only in DONE.
- Accept: on the edge where InValid && InReady, A, B and Opcode are captured into internal registers. Later input changes are ignored until the next accept.
- IDLE transitions:
  - Non-multiply op, or multiply with MUL_ITER=0: result and flags are written at the accept edge and the state goes to DONE. OutValid is high in the cycle after the accept (latency 1).
  - Multiply with MUL_ITER=1: the state goes to MUL with the accumulator=0 and the iteration counter=0.
- MUL state:
  - One iteration per clock: if multiplier LSB is 1, accumulator += shifted multiplicand; then the multiplicand shifts left and the multiplier shifts right.
  - After WIDTH iterations, the state goes to DONE. OutValid rises WIDTH+1 cycles after the accept edge.
- DONE state:
  - ALU_Out, CarryOut and Zero are held stable while OutReady=0.
  - On OutValid && OutReady, the state returns to IDLE. ALU_Out keeps its last value.
  - Throughput: at most one operation per 2 cycles. There is no accept in the same cycle as a drain.
- Arithmetic rule: operands are zero-extended to 2*WIDTH bits and every result is taken modulo 2^(2*WIDTH). Comparisons are unsigned. ">>>" on unsigned operands is a logical shift.
- Opcode map, result definitions:
  - 00000 A+B; 00001 A-B; 00010 A*B; 00011 B-A.
  - 00100 A+1; 00101 A-1; 00110 -A; 00111 -B.
  - 01000 A; 01001 B.
  - 01010/01100 A<<1; 01011/01101 A>>1.
  - 01110/10000 B<<1; 01111/10001 B>>1. Left shifts keep bit WIDTH.
  - 10010 rotate A left 1; 10011 rotate A right 1; 10100 rotate B left 1; 10101 rotate B right 1. Rotates are WIDTH-bit, then zero-extended.
  - 10110 ~A; 10111 ~B. Inversion is on the extended value, so the upper bits become 1.
  - 11000 AND; 11001 OR; 11010 XOR; 11011 NOR; 11100 NAND; 11101 XNOR. NOR, NAND and XNOR are on the extended value.
  - 11110 (A>B)?1:0; 11111 (A==B)?1:0.
- CarryOut, per opcode:
  - 00000: bit WIDTH of A+B.
  - 00001: borrow = (A<B).
  - 00011: borrow = (B<A).
  - 00100: A == all-ones.
  - 00101: A == 0.
  - All other opcodes: 0.
- Zero is computed from the final 2*WIDTH result and is registered together with it.
- Boundaries:
  - Multiply of all-ones operands must not overflow 2*WIDTH.
  - InValid asserted while InReady=0 is ignored and does not queue.
  - Reset and OutReady in the same cycle: reset wins.

Test Plan:
- WIDTH=8, ADD A=0xFF B=0x01, OutReady=1 -> OutValid in the cycle after the accept; ALU_Out=0x0100, CarryOut=1, Zero=0; back to IDLE one cycle later.
- MUL_ITER=1, MUL A=0xFF B=0xFF -> InReady=0 for 9 cycles; OutValid high 9 cycles after the accept; ALU_Out=0xFE01. Repeat with MUL_ITER=0 -> same value at latency 1.
- SUB A=0x03 B=0x05 -> ALU_Out=0xFFFE, CarryOut=1. Then B-A (00011) on the same operands -> 0x0002, CarryOut=0.
- Backpressure: XOR A=0xAA B=0xAA with OutReady=0 for 5 cycles -> ALU_Out=0x0000 and Zero=1 held stable, InReady=0. A second InValid pulse during the stall is ignored; exactly one result is delivered.
- Reset asserted during the 3rd MUL iteration -> next cycle: state IDLE, OutValid=0, InReady=1, ALU_Out=0, CarryOut=0, Zero=0. No stale result appears afterwards.
- Rotate/compare: ROL A=0x81 -> 0x0003. GT A=0x05 B=0x05 -> 0x0000 with Zero=1. EQ on the same operands -> 0x0001 with Zero=0.
